sample_capture: RTL and testbench

SAMPLE_CAPTURE -- requirements
Module: sample_capture

---
 rtl/sample_capture.sv | 172 +++++++++++++++++
 tb/tb_sample_capture.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_capture.sv
// Triggered ADC capture engine: arms on activate, waits for a level crossing
// (or a forced trigger), then streams decimated samples into a sample memory.
module sample_capture #(
  parameter int SAMPLE_DEPTH = 0,
  parameter int WIDTH        = 12,
  // A zero-bit address bus is not legal, so depth 0 still carries one address bit.
  localparam int AW = (SAMPLE_DEPTH > 0) ? SAMPLE_DEPTH : 1
) (
  input  logic             clk_50mhz,
  input  logic             reset,
  input  logic             activate,
  output logic             done,
  input  logic [WIDTH-1:0] adc_data,
  input  logic             adc_valid,
  input  logic [WIDTH-1:0] trig_level,
  input  logic             trig_rising,
  input  logic             trig_force,
  input  logic [7:0]       decim,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_data,
  output logic [2:0]       state_dbg
);

  // ADC side has no back-pressure: a sample is accepted on any cycle where
  // adc_valid is high and the FSM is in a state that consumes samples.

  localparam int unsigned   LAST_INT = (1 << SAMPLE_DEPTH) - 1;
  localparam logic [AW-1:0] LAST     = LAST_INT[AW-1:0];

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_TRIG = 3'd2,
    CAPTURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lvl_q, lvl_d;
  logic             rising_q, rising_d;
  logic [7:0]       decim_q, decim_d;
  logic             force_q, force_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             we_d;
  logic [AW-1:0]    maddr_d;
  logic [WIDTH-1:0] mdata_d;
  logic             trig_hit;
  logic             fire;

  assign trig_hit = rising_q ? ((prev_q < lvl_q) && (adc_data >= lvl_q))
                             : ((prev_q > lvl_q) && (adc_data <= lvl_q));
  // A pending force and a real crossing on the same sample collapse into one trigger.
  assign fire = trig_hit || force_q;

  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    rising_d = rising_q;
    decim_d  = decim_q;
    force_d  = force_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    maddr_d  = mem_addr;
    mdata_d  = mem_data;

    case (state_q)
      IDLE: begin
        force_d = 1'b0;
        if (activate) begin
          lvl_d    = trig_level;
          rising_d = trig_rising;
          decim_d  = decim;
          state_d  = ARM;
        end
      end

      ARM: begin
        if (!activate) begin
          force_d = 1'b0;
          state_d = IDLE;
        end else begin
          if (trig_force) force_d = 1'b1;
          if (adc_valid) begin
            prev_d  = adc_data;
            state_d = WAIT_TRIG;
          end
        end
      end

      WAIT_TRIG: begin
        if (!activate) begin
          force_d = 1'b0;
          state_d = IDLE;
        end else begin
          if (trig_force) force_d = 1'b1;
          if (adc_valid) begin
            prev_d = adc_data;
            if (fire) begin
              we_d    = 1'b1;
              maddr_d = '0;
              mdata_d = adc_data;
              force_d = 1'b0;
              cnt_d   = 8'd0;
              addr_d  = AW'(1);
              state_d = (SAMPLE_DEPTH == 0) ? DONE : CAPTURE;
            end
          end
        end
      end

      CAPTURE: begin
        if (!activate) begin
          state_d = IDLE;
        end else if (adc_valid) begin
          if (cnt_q == decim_q) begin
            cnt_d   = 8'd0;
            we_d    = 1'b1;
            maddr_d = addr_q;
            mdata_d = adc_data;
            addr_d  = addr_q + AW'(1);
            if (addr_q == LAST) state_d = DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      DONE: begin
        if (!activate) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state_q  <= IDLE;
      lvl_q    <= '0;
      rising_q <= 1'b0;
      decim_q  <= 8'd0;
      force_q  <= 1'b0;
      prev_q   <= '0;
      cnt_q    <= 8'd0;
      addr_q   <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      rising_q <= rising_d;
      decim_q  <= decim_d;
      force_q  <= force_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      mem_we   <= we_d;
      mem_addr <= maddr_d;
      mem_data <= mdata_d;
    end
  end

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture at SAMPLE_DEPTH=4, WIDTH=12: expected memory writes
// are queued as samples are driven and matched as mem_we pulses appear.
module tb_sample_capture;

  localparam int DEPTH = 4;
  localparam int W     = 12;

  // ---------------- clock / reset ----------------
  logic clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  logic          reset = 1'b1;
  logic          activate = 1'b0;
  logic [W-1:0]  adc_data = '0;
  logic          adc_valid = 1'b0;
  logic [W-1:0]  trig_level = '0;
  logic          trig_rising = 1'b0;
  logic          trig_force = 1'b0;
  logic [7:0]    decim = 8'd0;
  logic          done;
  logic          mem_we;
  logic [DEPTH-1:0] mem_addr;
  logic [W-1:0]  mem_data;
  logic [2:0]    state_dbg;

  sample_capture #(.SAMPLE_DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk_50mhz   (clk_50mhz),
    .reset       (reset),
    .activate    (activate),
    .done        (done),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .trig_force  (trig_force),
    .decim       (decim),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .state_dbg   (state_dbg)
  );

  int cyc = 0;
  always @(posedge clk_50mhz) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DEPTH+W-1:0] exp_q[$];
  int                 exp_cyc_q[$];

  always @(negedge clk_50mhz) begin
    if (!reset && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {16'h0, 4'(mem_addr), mem_data}, 32'hFFFF_FFFF);
      end else begin
        check_eq("write_addr_data", {mem_addr, mem_data}, exp_q.pop_front());
        check_eq("write_latency_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_capture(input logic [W-1:0] lvl, input logic rising, input logic [7:0] dec);
    @(posedge clk_50mhz); #1;
    trig_level  = lvl;
    trig_rising = rising;
    decim       = dec;
    activate    = 1'b1;
  endtask

  // One-cycle adc_valid strobe; a write (if expected) lands one cycle after the sampling edge.
  task automatic drive_sample(input logic [W-1:0] d, input bit exp_wr, input logic [DEPTH-1:0] ea);
    repeat ($urandom_range(0, 2)) @(posedge clk_50mhz);
    @(posedge clk_50mhz); #1;
    adc_data  = d;
    adc_valid = 1'b1;
    if (exp_wr) begin
      exp_q.push_back({ea, d});
      exp_cyc_q.push_back(cyc + 1);
    end
    @(posedge clk_50mhz); #1;
    adc_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_50mhz);
    @(negedge clk_50mhz); #1;
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  // Drops activate and expects done low one cycle later.
  task automatic release_capture(input string tag);
    activate = 1'b0;
    @(posedge clk_50mhz); #1;
    check_eq(tag, done, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] d;

  initial begin
    repeat (3) @(posedge clk_50mhz);
    #1;
    check_eq("reset_mem_we", mem_we, 0);
    check_eq("reset_mem_addr", mem_addr, 0);
    check_eq("reset_mem_data", mem_data, 0);
    check_eq("reset_done", done, 0);
    reset = 1'b0;

    // Rising trigger on a ramp, decim=0: 16 consecutive writes.
    start_capture(12'h800, 1'b1, 8'd0);
    drive_sample(12'h700, 0, 0);
    drive_sample(12'h7F0, 0, 0);
    drive_sample(12'h810, 1, 0);
    for (int i = 1; i < 16; i++) drive_sample(12'(12'h810 + 16 * i), 1, 4'(i));
    check_eq("rising_done_set", done, 1);
    wait_drain("rising_drain");

    // DONE holds with adc_valid toggling; no writes.
    for (int i = 0; i < 4; i++) drive_sample(12'($urandom_range(0, 4095)), 0, 0);
    check_eq("done_hold", done, 1);
    release_capture("done_release");

    // Falling trigger: 0x500 then 0x400 crosses.
    start_capture(12'h400, 1'b0, 8'd0);
    drive_sample(12'h500, 0, 0);
    drive_sample(12'h400, 1, 0);
    check_eq("falling_not_done", done, 0);
    wait_drain("falling_drain");
    release_capture("falling_abort_done");

    // No crossing: 0x3FF,0x3FF,0x400 never trigger on falling edge.
    start_capture(12'h400, 1'b0, 8'd0);
    drive_sample(12'h3FF, 0, 0);
    drive_sample(12'h3FF, 0, 0);
    drive_sample(12'h400, 0, 0);
    wait_drain("no_cross_drain");
    release_capture("no_cross_done");

    // Decimation by 3: only every third valid after the trigger is stored.
    start_capture(12'h800, 1'b1, 8'd2);
    drive_sample(12'h700, 0, 0);
    drive_sample(12'h900, 1, 0);
    for (int i = 1; i <= 45; i++) begin
      d = 12'($urandom_range(0, 4095));
      drive_sample(d, (i % 3) == 0, 4'(i / 3));
    end
    check_eq("decim_done_set", done, 1);
    wait_drain("decim_drain");
    release_capture("decim_release");

    // Forced trigger on a constant input.
    start_capture(12'h800, 1'b1, 8'd0);
    drive_sample(12'h123, 0, 0);
    drive_sample(12'h123, 0, 0);
    drive_sample(12'h123, 0, 0);
    @(posedge clk_50mhz); #1;
    trig_force = 1'b1;
    @(posedge clk_50mhz); #1;
    trig_force = 1'b0;
    for (int i = 0; i < 16; i++) drive_sample(12'h123, 1, 4'(i));
    check_eq("force_done_set", done, 1);
    wait_drain("force_drain");
    release_capture("force_release");

    // Abort after address 5: the in-flight write completes, nothing after.
    start_capture(12'h800, 1'b1, 8'd0);
    drive_sample(12'h700, 0, 0);
    drive_sample(12'h900, 1, 0);
    for (int i = 1; i <= 5; i++) drive_sample(12'(12'h900 + i), 1, 4'(i));
    activate = 1'b0;
    for (int i = 0; i < 4; i++) drive_sample(12'(12'hA00 + i), 0, 0);
    check_eq("abort_done", done, 0);
    wait_drain("abort_drain");

    // Reset in CAPTURE, coincident with a valid sample: everything zero next cycle.
    start_capture(12'h800, 1'b1, 8'd0);
    drive_sample(12'h700, 0, 0);
    drive_sample(12'h900, 1, 0);
    drive_sample(12'h901, 1, 1);
    wait_drain("pre_reset_drain");
    @(posedge clk_50mhz); #1;
    adc_data  = 12'h555;
    adc_valid = 1'b1;
    reset     = 1'b1;
    activate  = 1'b0;
    @(posedge clk_50mhz); #1;
    adc_valid = 1'b0;
    check_eq("midreset_mem_we", mem_we, 0);
    check_eq("midreset_mem_addr", mem_addr, 0);
    check_eq("midreset_mem_data", mem_data, 0);
    check_eq("midreset_done", done, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive_sample(12'h900, 0, 0);
    wait_drain("post_reset_idle");

    // Re-arm after reset works from a fresh activate.
    start_capture(12'h800, 1'b1, 8'd0);
    drive_sample(12'h100, 0, 0);
    drive_sample(12'hFFF, 1, 0);
    wait_drain("rearm_drain");
    release_capture("rearm_release");

    repeat (3) @(posedge clk_50mhz);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
